// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on start and {cout,sum} updates once, on the final bit step.
module serial_adder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);
   // state  | meaning
   // S_IDLE | waiting for start, operands captured on the accepting edge
   // S_RUN  | one bit step per cycle, N cycles
   // S_DONE | result valid, done strobe for one cycle

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state;
   logic [N-1:0]  sa, sb, ps;
   logic          c;
   logic [CW-1:0] cnt;

   logic          s_bit, c_next;
   logic [N-1:0]  ps_next;

   assign s_bit   = sa[0] ^ sb[0] ^ c;
   assign c_next  = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
   assign ps_next = {s_bit, ps[N-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         sa    <= '0;
         sb    <= '0;
         ps    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  c     <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sa  <= {1'b0, sa[N-1:1]};
               sb  <= {1'b0, sb[N-1:1]};
               ps  <= ps_next;
               c   <= c_next;
               cnt <= cnt + 1'b1;
               // sum/cout are loaded only here so they never show partial results
               if (cnt == LAST) begin
                  sum   <= ps_next;
                  cout  <= c_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (N=8): arithmetic/cycle model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_serial_adder;
   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a, b;
   logic         cin;
   logic         busy, done;
   logic [N-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;

   serial_adder #(.N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: cycles since acceptance; result is plain a+b+cin.
   int         phase = 0;
   logic [N:0] res   = '0;
   logic       eb = 1'b0, ed = 1'b0, ec = 1'b0;
   logic [N-1:0] es = '0;

   always @(posedge clk) begin
      if (rst) begin
         phase = 0; eb = 0; ed = 0; es = '0; ec = 0;
      end else if (phase == 0) begin
         ed = 0;
         if (start) begin
            res   = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
            phase = 1;
            eb    = 1;
         end
      end else if (phase < N) begin
         phase = phase + 1;
      end else if (phase == N) begin
         eb = 0; ed = 1;
         {ec, es} = res;
         phase = N + 1;
      end else begin
         ed = 0;
         phase = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      checks++;
      if ({busy, done, sum, cout} !== {eb, ed, es, ec}) begin
         errors++;
         $display("FAIL model t=%0t got busy=%b done=%b sum=%h cout=%b exp busy=%b done=%b sum=%h cout=%b",
                  $time, busy, done, sum, cout, eb, ed, es, ec);
      end
      checks++;
      if (busy && done) begin
         errors++;
         $display("FAIL busy_done_overlap t=%0t got both high exp not both", $time);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   // Pulse start, wait (bounded) for done, check literal result and busy length.
   task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input logic [7:0] xs, input logic xc, input string nm);
      int k, bc, sum_changes;
      logic [7:0] s0;
      @(negedge clk);
      s0 = sum;
      a = ta; b = tb; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; cin = $urandom;
      k = 0; bc = 0; sum_changes = 0;
      while (!done && k < 30) begin
         if (busy) bc++;
         if (sum !== s0) sum_changes++;
         @(negedge clk);
         k++;
      end
      chk({nm, "_timeout"}, (k < 30), 1);
      chk({nm, "_busy_len"}, bc, 8);
      chk({nm, "_sum_stable"}, sum_changes, 0);
      chk({nm, "_sum"}, sum, xs);
      chk({nm, "_cout"}, cout, xc);
   endtask

   initial begin
      int dn, k, last, ok_gap;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outs", {busy, done, sum, cout}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_outs", {busy, done, sum, cout}, 0);

      op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "basic");
      op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap");
      op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "allones");

      // Stray starts during RUN and DONE are dropped; operand changes ignored.
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 0; start = 1;
      @(negedge clk); start = 0;
      repeat (2) @(negedge clk);
      a = 8'hAA; b = 8'hAA; start = 1;
      @(negedge clk); start = 0; a = 8'h77;
      k = 0;
      while (!done && k < 30) begin @(negedge clk); k++; end
      chk("ignored_timeout", (k < 30), 1);
      chk("ignored_sum", {cout, sum}, 9'h046);
      start = 1;
      @(negedge clk); start = 0;
      dn = 0;
      repeat (20) begin if (done) dn++; @(negedge clk); end
      chk("ignored_done_count", dn, 0);
      chk("ignored_busy_after", busy, 0);

      // Back-to-back with start held high: done every N+2 cycles.
      a = 8'h80; b = 8'h80; cin = 0; start = 1;
      dn = 0; last = -1; ok_gap = 1;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (done) begin
            if (last >= 0 && (i - last) != 10) ok_gap = 0;
            if ({cout, sum} !== 9'h100) ok_gap = 0;
            last = i; dn++;
         end
      end
      start = 0;
      chk("b2b_count", dn, 3);
      chk("b2b_gap_and_result", ok_gap, 1);
      repeat (15) @(negedge clk);

      // Reset at the 4th RUN cycle aborts without a done pulse.
      a = 8'h55; b = 8'h55; cin = 0; start = 1;
      @(negedge clk); start = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk); rst = 0;
      chk("abort_outs", {busy, done, sum, cout}, 0);
      dn = 0;
      repeat (15) begin if (done) dn++; @(negedge clk); end
      chk("abort_no_done", dn, 0);
      op(8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, "after_abort");

      // Random traffic, including occasional resets; the model checks every cycle.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         a = $urandom; b = $urandom; cin = $urandom;
         rst = ($urandom_range(0, 99) == 0);
      end
      rst = 0; start = 0;
      repeat (15) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
